// File: rtl/moving_avg_pkg.sv
// Shared constants and helpers for the multi-channel moving average.
//   calc_len_w   : bits needed to hold a window length up to max_len
//   calc_acc_w   : accumulator width (sample width + length bits)
//   calc_shift_w : bits needed to hold a shift of 0..len_w
//   clamp_len    : 0 -> 1, above max_len -> max_len
//   clamp_shift  : above len_w -> len_w
package moving_avg_pkg;

    function automatic int calc_len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    function automatic int calc_acc_w(input int data_width, input int max_len);
        return data_width + calc_len_w(max_len);
    endfunction

    function automatic int calc_shift_w(input int len_w);
        return $clog2(len_w + 1);
    endfunction

    function automatic int clamp_len(input int len, input int max_len);
        if (len == 0) begin
            return 1;
        end
        if (len > max_len) begin
            return max_len;
        end
        return len;
    endfunction

    function automatic int clamp_shift(input int shift, input int len_w);
        return (shift > len_w) ? len_w : shift;
    endfunction

endpackage

// File: rtl/multi_ch_moving_avg_round_sat.sv
// Round-half-up, arithmetic right shift and saturation of one channel sum.
//   i_sum   : signed accumulator value (ACC_W bits)
//   i_shift : divisor exponent, already clamped to 0..ACC_W-DATA_WIDTH
//   o_data  : signed result clamped to the DATA_WIDTH range
module avg_round_sat
    import moving_avg_pkg::*;
#(
    parameter int ACC_W      = 27,
    parameter int DATA_WIDTH = 16,
    localparam int SHIFT_W   = calc_shift_w(ACC_W - DATA_WIDTH)
) (
    input  logic signed [ACC_W-1:0]      i_sum,
    input  logic        [SHIFT_W-1:0]    i_shift,
    output logic signed [DATA_WIDTH-1:0] o_data
);

    // One extra bit so adding the rounding term can never wrap.
    localparam int EXT_W = ACC_W + 1;
    localparam logic signed [EXT_W-1:0] ONE     = EXT_W'(1);
    localparam logic signed [EXT_W-1:0] SAT_MAX = (ONE <<< (DATA_WIDTH - 1)) - ONE;
    localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [EXT_W-1:0] w_ext;
    logic signed [EXT_W-1:0] w_rnd;
    logic signed [EXT_W-1:0] w_shr;

    always_comb begin
        w_ext = EXT_W'(i_sum);
        w_rnd = '0;
        if (i_shift != '0) begin
            w_rnd = ONE <<< (i_shift - 1'b1);
        end
        w_shr  = (w_ext + w_rnd) >>> i_shift;
        o_data = w_shr[DATA_WIDTH-1:0];
        if (w_shr > SAT_MAX) begin
            o_data = SAT_MAX[DATA_WIDTH-1:0];
        end else if (w_shr < SAT_MIN) begin
            o_data = SAT_MIN[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/multi_ch_moving_avg.sv
// Multi-channel boxcar moving average over an AXI-Stream of packed samples.
// Two stages: S1 reads the history RAM and updates the running sums,
// S2 rounds/saturates each channel into the output register.
//   clk, reset        : clock, synchronous active-high reset
//   clear             : synchronous flush; len/shift captured while high
//   len, shift        : window length and right-shift exponent
//   in_t*             : input stream, channel k in [k*DATA_WIDTH +: DATA_WIDTH]
//   out_t*            : averaged stream, same packing
//   out_primed        : beat was computed over a full window
module multi_ch_moving_avg
    import moving_avg_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NCHAN      = 2,
    parameter int MAX_LEN    = 2047,
    localparam int LEN_W     = calc_len_w(MAX_LEN),
    localparam int ACC_W     = calc_acc_w(DATA_WIDTH, MAX_LEN),
    localparam int SHIFT_W   = calc_shift_w(LEN_W)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic [LEN_W-1:0]            len,
    input  logic [SHIFT_W-1:0]          shift,
    input  logic [NCHAN*DATA_WIDTH-1:0] in_tdata,
    input  logic                        in_tlast,
    input  logic                        in_tvalid,
    output logic                        in_tready,
    output logic [NCHAN*DATA_WIDTH-1:0] out_tdata,
    output logic                        out_tlast,
    output logic                        out_tvalid,
    input  logic                        out_tready,
    output logic                        out_primed
);

    localparam int DEPTH  = 2 ** LEN_W;
    localparam int BEAT_W = NCHAN * DATA_WIDTH;

    logic                         w_load;
    logic                         w_en;
    logic                         w_accept;
    logic [LEN_W-1:0]             w_len_cl;
    logic [LEN_W-1:0]             w_len_nxt;
    logic [SHIFT_W-1:0]           w_shift_cl;
    logic [LEN_W-1:0]             r_len;
    logic [SHIFT_W-1:0]           r_shift;
    logic [LEN_W-1:0]             r_fill;
    logic [LEN_W-1:0]             w_fill_nxt;
    logic                         w_full;
    logic                         w_primed_nxt;
    logic [LEN_W-1:0]             r_wr_ptr;
    logic [LEN_W-1:0]             w_wr_ptr_nxt;
    logic [LEN_W-1:0]             w_rd_addr;

    logic [BEAT_W-1:0]            r_mem [DEPTH];
    logic [BEAT_W-1:0]            r_rd_data;
    logic                         r_byp;
    logic [BEAT_W-1:0]            r_byp_data;
    logic [BEAT_W-1:0]            w_old_beat;

    logic signed [DATA_WIDTH-1:0] w_x     [NCHAN];
    logic signed [DATA_WIDTH-1:0] w_old   [NCHAN];
    logic signed [ACC_W-1:0]      w_sum_nxt [NCHAN];
    logic signed [ACC_W-1:0]      r_sum   [NCHAN];

    logic                         r_s1_valid;
    logic                         r_s1_last;
    logic                         r_s1_primed;
    logic [BEAT_W-1:0]            w_rs_data;
    logic [BEAT_W-1:0]            r_out_data;
    logic                         r_out_valid;
    logic                         r_out_last;
    logic                         r_out_primed;

    assign w_load     = reset || clear;
    assign w_en       = !r_out_valid || out_tready;
    assign in_tready  = w_en && !w_load;
    assign w_accept   = in_tvalid && in_tready;

    assign w_len_cl   = LEN_W'(clamp_len(int'(len), MAX_LEN));
    assign w_shift_cl = SHIFT_W'(clamp_shift(int'(shift), LEN_W));
    assign w_len_nxt  = w_load ? w_len_cl : r_len;

    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        if (w_load) begin
            w_wr_ptr_nxt = '0;
        end else if (w_accept) begin
            w_wr_ptr_nxt = r_wr_ptr + 1'b1;
        end
    end

    // The read is issued one edge ahead for the pointer value the next
    // accept will see, so the registered RAM output is ready in time.
    assign w_rd_addr = w_wr_ptr_nxt - w_len_nxt;

    assign w_full       = (r_fill == r_len);
    assign w_fill_nxt   = w_full ? r_fill : r_fill + 1'b1;
    assign w_primed_nxt = (w_fill_nxt == r_len);

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= in_tdata;
        end
        r_rd_data <= r_mem[w_rd_addr];
    end

    // With len_r = 1 the read targets the word written on the same edge;
    // forward the written beat instead of the stale RAM word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_byp      <= 1'b0;
            r_byp_data <= '0;
        end else begin
            r_byp      <= w_accept && (w_rd_addr == r_wr_ptr);
            r_byp_data <= in_tdata;
        end
    end

    assign w_old_beat = r_byp ? r_byp_data : r_rd_data;

    always_comb begin
        w_x       = '{default: '0};
        w_old     = '{default: '0};
        w_sum_nxt = '{default: '0};
        for (int k = 0; k < NCHAN; k++) begin
            w_x[k]   = in_tdata[k*DATA_WIDTH +: DATA_WIDTH];
            // Until the window has filled, the RAM word is not a real sample.
            w_old[k] = w_full ? w_old_beat[k*DATA_WIDTH +: DATA_WIDTH] : '0;
            w_sum_nxt[k] = r_sum[k] + ACC_W'(w_x[k]) - ACC_W'(w_old[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_len       <= w_len_cl;
            r_shift     <= w_shift_cl;
            r_fill      <= '0;
            r_wr_ptr    <= '0;
            for (int k = 0; k < NCHAN; k++) begin
                r_sum[k] <= '0;
            end
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_primed <= 1'b0;
            r_out_valid <= 1'b0;
            if (reset) begin
                r_out_data   <= '0;
                r_out_last   <= 1'b0;
                r_out_primed <= 1'b0;
            end
        end else if (w_en) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                for (int k = 0; k < NCHAN; k++) begin
                    r_sum[k] <= w_sum_nxt[k];
                end
                r_fill      <= w_fill_nxt;
                r_wr_ptr    <= w_wr_ptr_nxt;
                r_s1_last   <= in_tlast;
                r_s1_primed <= w_primed_nxt;
            end
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data   <= w_rs_data;
                r_out_last   <= r_s1_last;
                r_out_primed <= r_s1_primed;
            end
        end
    end

    for (genvar k = 0; k < NCHAN; k++) begin : g_ch
        avg_round_sat #(
            .ACC_W      (ACC_W),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_round_sat (
            .i_sum   (r_sum[k]),
            .i_shift (r_shift),
            .o_data  (w_rs_data[k*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    assign out_tdata  = r_out_data;
    assign out_tvalid = r_out_valid;
    assign out_tlast  = r_out_last;
    assign out_primed = r_out_primed;

endmodule
